// File: rtl/arm_pkg.sv
// arm_pkg: shared instruction-fetch state type and constants
package arm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} imem_state_t;
  localparam logic [31:0] ARM_NOP = 32'hE1A00000;
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction word store, one synchronous read port and one write port, no reset
module imem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wa,
  input  logic [31:0]                    wd,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ra,
  output logic [31:0]                    rd
);
  logic [31:0] mem [DEPTH_WORDS];
  // a same-edge write to the read word still returns the old data
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: wait-stated instruction fetch responder with flush and freeze.
// Define INST_MEM_ADDR_CHECK_EN to flag misaligned or out-of-range fetches with rsp_err and a NOP.
module inst_mem_responder
  import arm_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [31:0] rsp_inst,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic        freeze,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);
  localparam int IW = $clog2(DEPTH_WORDS);
  imem_state_t state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, fetch_addr, rd_data;
  logic        have_data, err_q, accept, rd_en, bad, unused_bits;
  assign req_ready  = state == IDLE && !flush;
  assign accept     = req_valid && req_ready;
  assign rsp_valid  = state == RESP;
  assign freeze     = state == WAIT || (state == RESP && !rsp_ready);
  assign fetch_addr = state == IDLE ? req_addr : addr_q;
  // the read lands on the edge that enters RESP so the word appears together with rsp_valid
  assign rd_en = !flush && (state == IDLE ? accept && WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd1);
  assign rsp_inst = !have_data ? 32'h0 : err_q ? ARM_NOP : rd_data;
  assign rsp_err  = err_q;
  assign unused_bits = ^{ld_addr[31:IW+2], ld_addr[1:0], fetch_addr[31:IW+2], fetch_addr[1:0]};
`ifdef INST_MEM_ADDR_CHECK_EN
  assign bad = |fetch_addr[1:0] || |fetch_addr[31:IW+2];
`else
  assign bad = 1'b0;
`endif
  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk(clk),
    .we(ld_en),
    .wa(ld_addr[IW+1:2]),
    .wd(ld_data),
    .re(rd_en),
    .ra(fetch_addr[IW+1:2]),
    .rd(rd_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      have_data <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (flush) state <= IDLE;
      else if (accept) begin
        state  <= WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt    <= 4'(WAIT_CYCLES);
        addr_q <= req_addr;
      end else if (state == WAIT) begin
        state <= cnt == 4'd1 ? RESP : WAIT;
        cnt   <= cnt - 4'd1;
      end else if (state == RESP && rsp_ready) state <= IDLE;
      if (rd_en) begin
        have_data <= 1'b1;
        err_q     <= bad;
      end
    end
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: randomized and directed fetch traffic against a cycle-level reference model
module tb_inst_mem_responder;
  localparam int W = 2;
  localparam logic [31:0] NOP = 32'hE1A00000;
`ifdef INST_MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 0, rsp_ready = 0, flush = 0, ld_en = 0;
  logic [31:0] req_addr = 0, ld_addr = 0, ld_data = 0;
  logic req_ready, rsp_valid, rsp_err, freeze;
  logic [31:0] rsp_inst;
  logic req_valid0 = 0;
  logic [31:0] req_addr0 = 0;
  logic req_ready0, rsp_valid0, rsp_err0, freeze0;
  logic [31:0] rsp_inst0;
  int checks = 0, failures = 0;
  logic [31:0] mem_m [256];
  bit busy = 0, exp_err = 0;
  int due = 0, cyc = 0;
  logic [31:0] f_addr = 0, exp_inst = 0, last_inst = 0;

  always #5 clk = ~clk;

  inst_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_ready(rsp_ready),
    .rsp_err(rsp_err), .freeze(freeze), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  inst_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_addr(req_addr0), .req_ready(req_ready0),
    .flush(1'b0), .rsp_valid(rsp_valid0), .rsp_inst(rsp_inst0), .rsp_ready(1'b1),
    .rsp_err(rsp_err0), .freeze(freeze0), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock: drive inputs, check outputs against the model, then advance the model across the edge
  task automatic step(input bit rv, input logic [31:0] ra, input bit rr, input bit fl,
                      input bit le, input logic [31:0] la, input logic [31:0] ld);
    bit ev, bad;
    @(negedge clk);
    req_valid = rv; req_addr = ra; rsp_ready = rr; flush = fl;
    ld_en = le; ld_addr = la; ld_data = ld;
    #1;
    ev = busy && cyc >= due;
    if (ev) last_inst = exp_inst;
    chk("req_ready", 32'(req_ready), 32'(!busy && !fl));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("freeze", 32'(freeze), 32'(busy && (cyc < due || !rr)));
    chk("rsp_inst", rsp_inst, last_inst);
    if (ev) chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    if (fl) busy = 0;
    else if (rv && !busy) begin
      busy = 1; due = cyc + 1 + W; f_addr = ra;
    end else if (ev && rr) busy = 0;
    if (busy && cyc == due - 1) begin
      bad = CHK && (f_addr[1:0] != 2'b00 || f_addr >= 32'h400);
      exp_err = bad;
      exp_inst = bad ? NOP : mem_m[f_addr[9:2]];
    end
    if (le) mem_m[la[9:2]] = ld;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rr);
    repeat (n) step(0, 0, rr, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_inst", rsp_inst, 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_valid0", 32'(rsp_valid0), 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 256; i++) step(0, 0, 1, 0, 1, 32'(i) << 2, i == 0 ? 32'hE3A01005 : $urandom);
    // basic fetch of word 0 with two wait states
    step(1, 32'h0, 1, 0, 0, 0, 0);
    idle(4, 1);
    // stalled response held for four cycles, then one handshake
    step(1, 32'h8, 0, 0, 0, 0, 0);
    idle(6, 0);
    idle(3, 1);
    // flush one cycle after acceptance
    step(1, 32'hC, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    idle(5, 1);
    // out-of-range and misaligned fetches
    step(1, 32'h2, 1, 0, 0, 0, 0);
    idle(4, 1);
    step(1, 32'h400, 1, 0, 0, 0, 0);
    idle(4, 1);
    // write to the fetched word on the read edge returns old data
    step(1, 32'h10, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 32'h10, 32'hDEADBEEF);
    idle(3, 1);
    step(1, 32'h10, 1, 0, 0, 0, 0);
    idle(4, 1);
    // reset while waiting
    step(1, 32'h14, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("wrst_valid", 32'(rsp_valid), 0);
    chk("wrst_inst", rsp_inst, 0);
    chk("wrst_err", 32'(rsp_err), 0);
    chk("wrst_freeze", 32'(freeze), 0);
    busy = 0; last_inst = 0;
    @(negedge clk);
    rst = 0;
    step(1, 32'h4, 1, 0, 0, 0, 0);
    idle(4, 1);
    // zero-wait instance: back-to-back fetches of words 0 and 1
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid0 = 1;
      req_addr0 = ((i >> 1) & 1) != 0 ? 32'h4 : 32'h0;
      #1;
      chk("w0_ready", 32'(req_ready0), 32'(i % 2 == 0));
      chk("w0_valid", 32'(rsp_valid0), 32'(i % 2 == 1));
      chk("w0_freeze", 32'(freeze0), 0);
      if (i % 2 == 1) begin
        chk("w0_inst", rsp_inst0, mem_m[(i >> 1) & 1]);
        chk("w0_err", 32'(rsp_err0), 0);
      end
    end
    @(negedge clk);
    req_valid0 = 0;
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [31:0] ra;
      r = $urandom_range(0, 9);
      ra = r < 7 ? 32'($urandom_range(0, 63)) << 2 :
           r == 7 ? 32'h400 + (32'($urandom_range(0, 15)) << 2) :
           r == 8 ? (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3)) : $urandom;
      step($urandom_range(0, 2) != 0, ra, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0, 32'($urandom_range(0, 63)) << 2, $urandom);
    end
    idle(6, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
